// File: rtl/bus_mem_responder_if.sv
// rtl/bus_mem_responder_if.sv - OMNIBUS command/response encodings and the Bus_if master/slave interface
package Bus;
  typedef enum logic [2:0] {IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2} cmd_t;
  typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, ERR = 2'd3} resp_t;
endpackage

interface Bus_if;
  logic         MReset_n;
  logic [31:0]  MAddr;
  Bus::cmd_t    MCmd;
  logic [31:0]  MData;
  logic [3:0]   MByteEn;
  logic         MRespAccept;
  logic         SCmdAccept;
  logic [31:0]  SData;
  Bus::resp_t   SResp;

  modport master (
    output MReset_n, MAddr, MCmd, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SData, SResp
  );

  modport slave (
    input  MReset_n, MAddr, MCmd, MData, MByteEn, MRespAccept,
    output SCmdAccept, SData, SResp
  );
endinterface

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - OMNIBUS slave terminating reads/writes in a local word memory
module bus_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int          ADDR_WIDTH = 8,
  parameter int          LATENCY    = 1
) (
  input logic  clk,
  input logic  reset_n,
  Bus_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_countdown;
  logic        r_cmd_accept;
  logic [31:0] r_sdata;
  Bus::resp_t  r_sresp;
  logic [31:0] r_rdata;
  logic        r_rd_in_range;
  logic [31:0] r_mem [DEPTH];

  logic [31:0] w_idx;
  logic        w_in_range;
  logic        w_wr_fire;
  logic        w_rd_fire;
  logic [31:0] w_rd_word;

  // Unsigned wrap makes addresses below BASE_ADDR land far above the window.
  assign w_idx      = bus.MAddr - BASE_ADDR;
  assign w_in_range = (bus.MAddr >= BASE_ADDR) && ((w_idx >> ADDR_WIDTH) == 32'd0);
  assign w_wr_fire  = bus.MReset_n && r_cmd_accept && (bus.MCmd == Bus::WRITE) && w_in_range;
  assign w_rd_fire  = bus.MReset_n && r_cmd_accept && (bus.MCmd == Bus::READ);
  assign w_rd_word  = w_in_range ? r_mem[w_idx[ADDR_WIDTH-1:0]] : 32'd0;

  assign bus.SCmdAccept = r_cmd_accept;
  assign bus.SData      = r_sdata;
  assign bus.SResp      = r_sresp;

  // Memory is never reset; soft and hard resets leave contents intact.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.MByteEn[i]) begin
          r_mem[w_idx[ADDR_WIDTH-1:0]][8*i +: 8] <= bus.MData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_countdown   <= 4'd0;
      r_cmd_accept  <= 1'b1;
      r_sresp       <= Bus::NULL;
      r_sdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rd_in_range <= 1'b0;
    end else if (!bus.MReset_n) begin
      r_state       <= S_IDLE;
      r_countdown   <= 4'd0;
      r_cmd_accept  <= 1'b1;
      r_sresp       <= Bus::NULL;
      r_sdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rd_in_range <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_fire) begin
            r_cmd_accept  <= 1'b0;
            r_rdata       <= w_rd_word;
            r_rd_in_range <= w_in_range;
            r_countdown   <= 4'(LATENCY - 1);
            if (LATENCY > 1) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_RESP;
              r_sresp <= w_in_range ? Bus::DVA : Bus::ERR;
              r_sdata <= w_rd_word;
            end
          end
        end
        S_WAIT: begin
          if (r_countdown == 4'd1) begin
            r_state     <= S_RESP;
            r_countdown <= 4'd0;
            r_sresp     <= r_rd_in_range ? Bus::DVA : Bus::ERR;
            r_sdata     <= r_rdata;
          end else begin
            r_countdown <= r_countdown - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.MRespAccept) begin
            r_state      <= S_IDLE;
            r_cmd_accept <= 1'b1;
            r_sresp      <= Bus::NULL;
            r_sdata      <= 32'd0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cmd_accept <= 1'b1;
          r_sresp      <= Bus::NULL;
          r_sdata      <= 32'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - scoreboard bench for bus_mem_responder at LATENCY 1 and 3
module tb_bus_mem_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  Bus_if bif1 ();
  Bus_if bif3 ();

  logic        m_sel;
  logic        m_reset_n;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  Bus::cmd_t   m_cmd;
  logic [3:0]  m_be;
  logic        m_racc;

  assign bif1.MReset_n    = m_reset_n;
  assign bif1.MAddr       = m_addr;
  assign bif1.MCmd        = m_sel ? Bus::IDLE : m_cmd;
  assign bif1.MData       = m_data;
  assign bif1.MByteEn     = m_be;
  assign bif1.MRespAccept = m_racc;
  assign bif3.MReset_n    = m_reset_n;
  assign bif3.MAddr       = m_addr;
  assign bif3.MCmd        = m_sel ? m_cmd : Bus::IDLE;
  assign bif3.MData       = m_data;
  assign bif3.MByteEn     = m_be;
  assign bif3.MRespAccept = m_racc;

  logic        w_acc;
  Bus::resp_t  w_resp;
  logic [31:0] w_sdata;
  assign w_acc   = m_sel ? bif3.SCmdAccept : bif1.SCmdAccept;
  assign w_resp  = m_sel ? bif3.SResp : bif1.SResp;
  assign w_sdata = m_sel ? bif3.SData : bif1.SData;

  bus_mem_responder #(.BASE_ADDR(32'h100), .ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bif1));
  bus_mem_responder #(.BASE_ADDR(32'h100), .ADDR_WIDTH(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bif3));

  typedef struct {
    Bus::resp_t  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [2][256];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic bit in_rng(logic [31:0] a);
    return (a >= 32'h100) && ((a - 32'h100) < 32'd256);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called on a negedge; returns on the negedge after the transfer with MCmd back to IDLE.
  task automatic issue(Bus::cmd_t cmd, logic [31:0] a, logic [31:0] d, logic [3:0] be, output int waits);
    logic [31:0] ix;
    exp_t e;
    m_cmd = cmd; m_addr = a; m_data = d; m_be = be; waits = 0;
    while (!w_acc && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!w_acc) chk("accept_timeout", 32'(w_acc), 32'd1);
    @(posedge clk);
    ix = a - 32'h100;
    if (cmd == Bus::WRITE && in_rng(a)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[m_sel][ix[7:0]][8*i +: 8] = d[8*i +: 8];
    end
    if (cmd == Bus::READ) begin
      e.resp = in_rng(a) ? Bus::DVA : Bus::ERR;
      e.data = in_rng(a) ? mdl[m_sel][ix[7:0]] : 32'd0;
      sb.push_back(e);
    end
    @(negedge clk);
    m_cmd = Bus::IDLE;
  endtask

  task automatic wait_resp(int lat);
    int n = 0;
    while (w_resp == Bus::NULL && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat - 1));
    chk("acc_during_resp", 32'(w_acc), 32'd0);
  endtask

  task automatic take_resp(string tag);
    exp_t e;
    if (sb.size() == 0) chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_resp"}, 32'(w_resp), 32'(e.resp));
      chk({tag, "_data"}, w_sdata, e.data);
    end
  endtask

  task automatic handshake(string tag);
    m_racc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_racc = 1'b0;
    chk({tag, "_resp_null"}, 32'(w_resp), 32'(Bus::NULL));
    chk({tag, "_acc_back"}, 32'(w_acc), 32'd1);
  endtask

  task automatic do_read(string tag, logic [31:0] a);
    int w;
    issue(Bus::READ, a, 32'd0, 4'hF, w);
    wait_resp(m_sel ? 3 : 1);
    take_resp(tag);
    handshake(tag);
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    int w;
    issue(Bus::WRITE, a, d, be, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] s0;
    m_sel = 1'b0; m_reset_n = 1'b1; m_cmd = Bus::IDLE; m_addr = '0; m_data = '0; m_be = '0; m_racc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_acc1", 32'(bif1.SCmdAccept), 32'd1);
    chk("rst_resp1", 32'(bif1.SResp), 32'(Bus::NULL));
    chk("rst_data1", bif1.SData, 32'd0);
    chk("rst_acc3", 32'(bif3.SCmdAccept), 32'd1);
    chk("rst_resp3", 32'(bif3.SResp), 32'(Bus::NULL));
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write/read and byte-lane merge at LATENCY=1
    do_write(32'h100, 32'hDEADBEEF, 4'b1111);
    do_read("rd100", 32'h100);
    do_write(32'h101, 32'h11223344, 4'b1111);
    do_write(32'h101, 32'hAABBCCDD, 4'b0101);
    do_read("rd101_be", 32'h101);

    // Out of range: below base errors, above window is dropped
    do_read("rd0ff_err", 32'h0FF);
    do_write(32'h200, 32'h55555555, 4'b1111);
    do_read("rd100_after_oor", 32'h100);

    // Illegal command is ignored
    issue(Bus::cmd_t'(3'd5), 32'h100, 32'h0, 4'hF, w);
    chk("illegal_acc", 32'(w_acc), 32'd1);
    chk("illegal_resp", 32'(w_resp), 32'(Bus::NULL));

    // LATENCY=3 with response backpressure and a write held off meanwhile
    m_sel = 1'b1;
    do_write(32'h100, 32'h12345678, 4'b1111);
    issue(Bus::READ, 32'h100, 32'h0, 4'hF, w);
    wait_resp(3);
    s0 = w_sdata;
    m_cmd = Bus::WRITE; m_addr = 32'h102; m_data = 32'hCAFEF00D; m_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", w_sdata, s0);
      chk("bp_hold_acc", 32'(w_acc), 32'd0);
    end
    take_resp("bp_rd100");
    handshake("bp");
    @(posedge clk);
    mdl[1][2] = 32'hCAFEF00D;
    @(negedge clk);
    m_cmd = Bus::IDLE;
    do_read("rd102_after_bp", 32'h102);

    // Soft reset during WAIT discards the read and keeps memory
    issue(Bus::READ, 32'h100, 32'h0, 4'hF, w);
    m_reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_acc", 32'(w_acc), 32'd1);
    chk("mrst_resp", 32'(w_resp), 32'(Bus::NULL));
    m_reset_n = 1'b1;
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(w_resp), 32'(Bus::NULL));
    end
    do_read("rd100_after_mrst", 32'h100);

    // Hard reset during RESP clears outputs without a clock edge
    m_sel = 1'b0;
    issue(Bus::READ, 32'h101, 32'h0, 4'hF, w);
    chk("arst_pre_resp", 32'(w_resp), 32'(Bus::DVA));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_resp", 32'(w_resp), 32'(Bus::NULL));
    chk("arst_acc", 32'(w_acc), 32'd1);
    chk("arst_data", w_sdata, 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_read("rd101_after_arst", 32'h101);

    // Throughput up to the top word, then read back
    for (int i = 0; i < 16; i++) begin
      issue(Bus::WRITE, 32'h1F0 + 32'(i), $urandom, 4'hF, w);
      chk("tput_no_stall", 32'(w), 32'd0);
    end
    for (int i = 0; i < 16; i++) do_read("tput_rd", 32'h1F0 + 32'(i));
    do_read("rd100_final", 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
